// File: rtl/fft4_pkg.sv
// Shared types and constants for the 4-point FFT sequencer.
// Twiddles are integer unit values that match the butterfly's truncation.
package fft4_pkg;

    localparam int FFT_WIDTH = 32;
    localparam int HALF      = FFT_WIDTH / 2;
    localparam int MAX_W     = 64;

    typedef enum logic [2:0] {
        LOAD,
        BF0,
        BF1,
        BF2,
        BF3,
        OUT
    } state_t;

    // Bit-reversed drain order: X0, X1, X2, X3 live in buf 0, 2, 1, 3.
    localparam logic [7:0] OUT_ORDER = {2'd3, 2'd1, 2'd2, 2'd0};

    function automatic logic [MAX_W-1:0] tw_w0(int w);
        return MAX_W'(1) << (w / 2);
    endfunction

    function automatic logic [MAX_W-1:0] tw_w1(int w);
        return (MAX_W'(1) << (w / 2)) - MAX_W'(1);
    endfunction

    function automatic logic [1:0] out_idx(logic [1:0] k);
        return OUT_ORDER[2*k +: 2];
    endfunction

endpackage

// File: rtl/fft4_sequencer_if.sv
// Sample-in / bin-out valid-ready streams of the FFT sequencer.
interface fft4_sequencer_if #(
    parameter int WIDTH = 32
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last
    );

endinterface

// File: rtl/fft4_sequencer.sv
// Load 4 samples, run 4 butterfly steps on an external butterfly,
// then stream X0..X3 in natural order.
module fft4_sequencer
    import fft4_pkg::*;
#(
    parameter int WIDTH = FFT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    fft4_sequencer_if.slave  io,
    output logic             busy,
    output logic [WIDTH-1:0] bf_a,
    output logic [WIDTH-1:0] bf_b,
    output logic [WIDTH-1:0] bf_w,
    input  logic [WIDTH-1:0] bf_out0,
    input  logic [WIDTH-1:0] bf_out1
);

    localparam logic [WIDTH-1:0] W0 = WIDTH'(tw_w0(WIDTH));
    localparam logic [WIDTH-1:0] W1 = WIDTH'(tw_w1(WIDTH));

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [WIDTH-1:0] buf_q [4];
    logic [WIDTH-1:0] buf_d [4];
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic in_fire;
    logic out_fire;

    assign in_fire  = io.in_valid && in_ready_q;
    assign out_fire = out_valid_q && io.out_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        buf_d       = buf_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        bf_a        = '0;
        bf_b        = '0;
        bf_w        = '0;
        unique case (state_q)
            LOAD: begin
                if (in_fire) begin
                    buf_d[cnt_q] = io.in_data;
                    cnt_d        = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = BF0;
                end
            end
            BF0: begin
                bf_a     = buf_q[0];
                bf_b     = buf_q[2];
                bf_w     = W0;
                buf_d[0] = bf_out0;
                buf_d[2] = bf_out1;
                state_d  = BF1;
            end
            BF1: begin
                bf_a     = buf_q[1];
                bf_b     = buf_q[3];
                bf_w     = W0;
                buf_d[1] = bf_out0;
                buf_d[3] = bf_out1;
                state_d  = BF2;
            end
            BF2: begin
                bf_a     = buf_q[0];
                bf_b     = buf_q[1];
                bf_w     = W0;
                buf_d[0] = bf_out0;
                buf_d[1] = bf_out1;
                state_d  = BF3;
            end
            BF3: begin
                bf_a     = buf_q[2];
                bf_b     = buf_q[3];
                bf_w     = W1;
                buf_d[2] = bf_out0;
                buf_d[3] = bf_out1;
                idx_d    = 2'd0;
                state_d  = OUT;
            end
            OUT: begin
                // First OUT cycle only registers beat 0; beats then flow.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = buf_q[out_idx(idx_q)];
                    out_last_d  = (idx_q == 2'd3);
                end else if (out_fire) begin
                    if (idx_q == 2'd3) begin
                        state_d     = LOAD;
                        idx_d       = 2'd0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_data_d  = '0;
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        out_data_d = buf_q[out_idx(idx_d)];
                        out_last_d = (idx_d == 2'd3);
                    end
                end
            end
            default: state_d = LOAD;
        endcase
        in_ready_d = (state_d == LOAD);
        busy_d     = (state_d != LOAD) || (cnt_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            cnt_q       <= 2'd0;
            idx_q       <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < 4; i++) buf_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            out_data_q  <= out_data_d;
            for (int i = 0; i < 4; i++) buf_q[i] <= buf_d[i];
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.out_last  = out_last_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_fft4_sequencer.sv
// Directed bench for fft4_sequencer with a behavioural butterfly
// attached to the bf_* ports.
module tb_fft4_sequencer;
    import fft4_pkg::*;

    localparam int W = 32;

    typedef logic [3:0][W-1:0] frame_t;

    typedef struct {
        string  nm;
        frame_t x;
        frame_t y;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         busy;
    logic [W-1:0] bf_a, bf_b, bf_w;
    logic [W-1:0] bf_out0, bf_out1;

    int total;
    int passed;

    fft4_sequencer_if #(.WIDTH(W)) sif ();

    fft4_sequencer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .io      (sif.slave),
        .busy    (busy),
        .bf_a    (bf_a),
        .bf_b    (bf_b),
        .bf_w    (bf_w),
        .bf_out0 (bf_out0),
        .bf_out1 (bf_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic signed [HALF-1:0]   ar, ai, br, bi, wr, wi;
    logic signed [2*HALF-1:0] pr, pi;

    always_comb begin
        ar      = bf_a[2*HALF-1:HALF];
        ai      = bf_a[HALF-1:0];
        br      = bf_b[2*HALF-1:HALF];
        bi      = bf_b[HALF-1:0];
        wr      = bf_w[2*HALF-1:HALF];
        wi      = bf_w[HALF-1:0];
        pr      = br * wr - bi * wi;
        pi      = br * wi + bi * wr;
        bf_out0 = {ar + pr[HALF-1:0], ai + pi[HALF-1:0]};
        bf_out1 = {ar - pr[HALF-1:0], ai - pi[HALF-1:0]};
    end

    function automatic void chk(string nm, logic [W-1:0] act,
                                logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endfunction

    function automatic frame_t mk(logic [W-1:0] a, logic [W-1:0] b,
                                  logic [W-1:0] c, logic [W-1:0] d);
        frame_t r;
        r[0] = a;
        r[1] = b;
        r[2] = c;
        r[3] = d;
        return r;
    endfunction

    task automatic push(input logic [W-1:0] x, input bit gap);
        int w;
        @(negedge clk);
        if (gap) begin
            sif.in_valid = 1'b0;
            @(negedge clk);
        end
        sif.in_valid = 1'b1;
        sif.in_data  = x;
        w = 0;
        while (!sif.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) chk("push_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic get_frame(input int stall, input string nm,
                             output frame_t d, output logic [3:0] l);
        int          w;
        int          bad;
        logic [W-1:0] snap;
        bad = 0;
        for (int b = 0; b < 4; b++) begin
            sif.out_ready = 1'b0;
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!sif.out_valid && w < 40);
            if (!sif.out_valid) chk({nm, "_valid_timeout"}, 32'd0, 32'd1);
            snap = sif.out_data;
            repeat (stall) begin
                @(negedge clk);
                if (sif.out_data !== snap || !sif.out_valid) bad++;
            end
            sif.out_ready = 1'b1;
            d[b] = sif.out_data;
            l[b] = sif.out_last;
            @(posedge clk);
            #1;
        end
        sif.out_ready = 1'b0;
        if (stall > 0) chk({nm, "_stall_stable"}, W'(bad), 32'd0);
        chk({nm, "_post_valid"}, W'(sif.out_valid), 32'd0);
        chk({nm, "_post_ready"}, W'(sif.in_ready), 32'd1);
    endtask

    task automatic finish_frame(input frame_t y, input int stall,
                                input bit garbage, input string nm);
        int     lat;
        int     rdy_seen;
        frame_t d;
        logic [3:0] l;
        if (garbage) begin
            sif.in_valid = 1'b1;
            sif.in_data  = 32'hDEAD_BEEF;
        end else begin
            sif.in_valid = 1'b0;
        end
        lat      = 0;
        rdy_seen = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (sif.in_ready) rdy_seen++;
            if (sif.out_valid) begin
                lat = c;
                break;
            end
        end
        chk({nm, "_latency"}, W'(lat), 32'd5);
        chk({nm, "_ready_low"}, W'(rdy_seen), 32'd0);
        get_frame(stall, nm, d, l);
        sif.in_valid = 1'b0;
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_X%0d", nm, k), d[k], y[k]);
        chk({nm, "_last"}, W'(l), 32'h8);
    endtask

    task automatic run_frame(input frame_t x, input frame_t y,
                             input int stall, input bit gap,
                             input bit garbage, input string nm);
        for (int i = 0; i < 4; i++) push(x[i], gap);
        finish_frame(y, stall, garbage, nm);
    endtask

    vec_t   vecs [4];
    frame_t ramp_x, ramp_y;

    initial begin
        total         = 0;
        passed        = 0;
        rst_n         = 1'b0;
        sif.in_valid  = 1'b0;
        sif.in_data   = '0;
        sif.out_ready = 1'b0;

        ramp_x = mk(32'h0001_0000, 32'h0002_0000,
                    32'h0003_0000, 32'h0004_0000);
        ramp_y = mk(32'h000A_0000, 32'hFFFE_0002,
                    32'hFFFE_0000, 32'hFFFE_FFFE);
        vecs[0] = '{nm: "ramp", x: ramp_x, y: ramp_y};
        vecs[1] = '{nm: "impulse",
                    x: mk(32'h0005_0000, 0, 0, 0),
                    y: mk(32'h0005_0000, 32'h0005_0000,
                          32'h0005_0000, 32'h0005_0000)};
        vecs[2] = '{nm: "mixed",
                    x: mk(32'h0000_0001, 32'h0001_0000, 0, 0),
                    y: mk(32'h0001_0001, 32'h0000_0000,
                          32'hFFFF_0001, 32'h0000_0002)};
        vecs[3] = '{nm: "wrap",
                    x: mk(32'h7FFF_0000, 32'h7FFF_0000,
                          32'h7FFF_0000, 32'h7FFF_0000),
                    y: mk(32'hFFFC_0000, 0, 0, 0)};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", W'(sif.in_ready), 32'd1);
        chk("rst_out_valid", W'(sif.out_valid), 32'd0);
        chk("rst_out_last", W'(sif.out_last), 32'd0);
        chk("rst_busy", W'(busy), 32'd0);
        chk("rst_bf_a", bf_a, 32'd0);
        chk("rst_bf_w", bf_w, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++)
            run_frame(vecs[v].x, vecs[v].y, 0, 1'b0, 1'b0, vecs[v].nm);

        run_frame(ramp_x, ramp_y, 3, 1'b0, 1'b0, "backpressure");
        run_frame(ramp_x, ramp_y, 0, 1'b1, 1'b1, "gapped");

        push(ramp_x[0], 1'b0);
        push(ramp_x[1], 1'b0);
        sif.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("partial_busy", W'(busy), 32'd1);
        chk("partial_ready", W'(sif.in_ready), 32'd1);
        chk("partial_valid", W'(sif.out_valid), 32'd0);
        push(ramp_x[2], 1'b0);
        push(ramp_x[3], 1'b0);
        finish_frame(ramp_y, 0, 1'b0, "partial");

        for (int i = 0; i < 4; i++) push(ramp_x[i], 1'b0);
        sif.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mid_bf2_a", bf_a, 32'h0004_0000);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", W'(sif.in_ready), 32'd1);
        chk("mid_rst_valid", W'(sif.out_valid), 32'd0);
        chk("mid_rst_busy", W'(busy), 32'd0);
        chk("mid_rst_bf_a", bf_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(ramp_x, ramp_y, 0, 1'b0, 1'b0, "after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

endmodule
